// File: rtl/axis_frame_source.sv
// AXI-Stream frame replay source: one image in on-chip RAM, streamed for a programmable number of frames.
// Optional per-frame checksum output is enabled by defining AXIS_FRAME_SRC_CSUM_EN.
module axis_frame_source #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int FRM_W  = 8,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              done,
  output logic [FRM_W-1:0]  frame_cnt
`ifdef AXIS_FRAME_SRC_CSUM_EN
  ,
  output logic [31:0]       frame_csum
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, GAP} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  // Stage A is the RAM output register; stage S is the skid slot that absorbs one beat under backpressure.
  logic              a_valid, a_last, a_user;
  logic              s_valid, s_last, s_user;
  logic [DATA_W-1:0] s_data;

  logic [ADDR_W:0]   len_q, len_in;
  logic [FRM_W-1:0]  nf_q, rd_frm;
  logic [GAP_W-1:0]  gap_q, gap_ctr;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_active, rd_en, rd_is_last, rd_more;
  logic              pop, last_pop, frames_done;

  assign len_in = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;

  assign m_axis_tvalid = s_valid | a_valid;
  assign m_axis_tdata  = s_valid ? s_data : (a_valid ? ram_q : '0);
  assign m_axis_tlast  = s_valid ? s_last : (a_valid & a_last);
  assign m_axis_tuser  = s_valid ? s_user : (a_valid & a_user);

  assign pop         = m_axis_tvalid & m_axis_tready;
  assign last_pop    = pop & m_axis_tlast;
  assign frames_done = ({1'b0, frame_cnt} + (FRM_W+1)'(1)) == {1'b0, nf_q};
  assign rd_is_last  = {1'b0, rd_idx} == (len_q - (ADDR_W+1)'(1));
  assign rd_more     = (gap_q == '0) && (({1'b0, rd_frm} + (FRM_W+1)'(1)) < {1'b0, nf_q});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (start && frame_len != '0 && num_frames != '0) state_next = PRIME;
        PRIME:  state_next = STREAM;
        STREAM: if (last_pop) begin
                  if (frames_done)          state_next = IDLE;
                  else if (gap_q != '0)     state_next = GAP;
                end
        GAP:    if (gap_ctr == GAP_W'(1)) state_next = STREAM;
        default: state_next = IDLE;
      endcase
    end
  end

  // A new read may only be issued if the beat it displaces from stage A has somewhere to go.
  always_comb begin
    busy  = (state != IDLE);
    rd_en = 1'b0;
    case (state)
      PRIME:   rd_en = 1'b1;
      STREAM:  rd_en = rd_active & ~(s_valid & a_valid & ~m_axis_tready);
      GAP:     rd_en = (gap_ctr == GAP_W'(1));
      default: rd_en = 1'b0;
    endcase
    if (abort) rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  ram_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      nf_q      <= '0;
      gap_q     <= '0;
      gap_ctr   <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      rd_idx    <= '0;
      rd_frm    <= '0;
      rd_active <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        rd_active <= 1'b0;
        rd_idx    <= '0;
      end else begin
        if (state == IDLE && start) begin
          len_q     <= len_in;
          nf_q      <= num_frames;
          gap_q     <= gap_cycles;
          frame_cnt <= '0;
          rd_idx    <= '0;
          rd_frm    <= '0;
          rd_active <= 1'b0;
          done      <= (frame_len == '0) || (num_frames == '0);
        end
        if (last_pop) begin
          frame_cnt <= frame_cnt + FRM_W'(1);
          done      <= frames_done;
          gap_ctr   <= gap_q;
        end else if (state == GAP) begin
          gap_ctr <= gap_ctr - GAP_W'(1);
        end
        // Back-to-back frames keep the read side running straight into the next frame's address 0.
        if (rd_en) begin
          if (rd_is_last) begin
            rd_idx    <= '0;
            rd_frm    <= rd_frm + FRM_W'(1);
            rd_active <= rd_more;
          end else begin
            rd_idx    <= rd_idx + ADDR_W'(1);
            rd_active <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      a_user  <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_user  <= 1'b0;
      s_data  <= '0;
    end else if (rd_en) begin
      a_valid <= 1'b1;
      a_last  <= rd_is_last;
      a_user  <= (rd_idx == '0);
      if (!(s_valid && !pop)) begin
        s_valid <= s_valid ? a_valid : (a_valid & ~pop);
        s_data  <= ram_q;
        s_last  <= a_last;
        s_user  <= a_user;
      end
    end else if (pop) begin
      if (s_valid) s_valid <= 1'b0;
      else         a_valid <= 1'b0;
    end
  end

`ifdef AXIS_FRAME_SRC_CSUM_EN
  logic [31:0] csum_acc;

  // The accumulator restarts with every frame; a flushed partial frame never reaches frame_csum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_acc   <= '0;
      frame_csum <= '0;
    end else if (abort || (state == IDLE && start)) begin
      csum_acc <= '0;
    end else if (pop) begin
      if (m_axis_tlast) begin
        frame_csum <= csum_acc + 32'(m_axis_tdata);
        csum_acc   <= '0;
      end else begin
        csum_acc <= csum_acc + 32'(m_axis_tdata);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: a beat-queue model checked on every handshake plus directed timing checks.
// Covers AXIS_FRAME_SRC_CSUM_EN when that macro is defined for the build.
module tb_axis_frame_source;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int FRM_W  = 8;
  localparam int GAP_W  = 16;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int LIMIT  = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_waddr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   frame_len = '0;
  logic [FRM_W-1:0]  num_frames = '0;
  logic [GAP_W-1:0]  gap_cycles = '0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              busy;
  logic              done;
  logic [FRM_W-1:0]  frame_cnt;
`ifdef AXIS_FRAME_SRC_CSUM_EN
  logic [31:0]       frame_csum;
`endif

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram_model [DEPTH];
  logic [DATA_W+1:0] exp_q [$];

  axis_frame_source #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRM_W(FRM_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .start(start), .abort(abort),
    .frame_len(frame_len), .num_frames(num_frames), .gap_cycles(gap_cycles),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
`ifdef AXIS_FRAME_SRC_CSUM_EN
    , .frame_csum(frame_csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every handshake pops the model queue; a held beat under backpressure must not change.
  logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
  logic [DATA_W+1:0] prev_beat = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid && !prev_ready && !prev_abort) begin
        check_output("stall_valid", m_axis_tvalid, 1);
        check_output("stall_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check_output("unexpected_beat", 1, 0);
        else check_output("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      prev_valid = m_axis_tvalid;
      prev_ready = m_axis_tready;
      prev_abort = abort;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic apply_stimulus_load(input int first, input int count, input int base);
    for (int i = first; i < first + count; i++) begin
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(i);
      mem_wdata = DATA_W'(base + i);
      ram_model[i] = DATA_W'(base + i);
      @(posedge clk); #1;
    end
    mem_we = 1'b0;
  endtask

  // ready_mode 0: tready always high; 1: repeating 1,0,0,1 with a stray start pulse mid-run.
  task automatic apply_stimulus_run(input int len, input int nf, input int gap, input int ready_mode, input int exp_done);
    int eff, c;
    bit seen, active;
    logic [3:0] pat;
    pat = 4'b1001;
    eff = (len > DEPTH) ? DEPTH : len;
    active = (eff > 0) && (nf > 0);
    if (active)
      for (int f = 0; f < nf; f++)
        for (int k = 0; k < eff; k++)
          exp_q.push_back({(k == 0), (k == eff - 1), ram_model[k]});
    frame_len  = (ADDR_W+1)'(len);
    num_frames = FRM_W'(nf);
    gap_cycles = GAP_W'(gap);
    m_axis_tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", busy, active);
    c = 0;
    seen = 0;
    while (!seen && c < LIMIT) begin
      if (c == 0) check_output("prime_no_valid", m_axis_tvalid, 0);
      if (c == 1 && active) check_output("first_valid_t2", {m_axis_tvalid, m_axis_tuser}, 2'b11);
      if (done) seen = 1;
      else begin
        m_axis_tready = (ready_mode == 1) ? pat[c % 4] : 1'b1;
        start = (ready_mode == 1 && c == 6);
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    check_output("done_seen", seen, 1);
    if (exp_done >= 0) check_output("done_cycle", c, exp_done);
    check_output("end_idle", {busy, m_axis_tvalid}, 2'b00);
    check_output("frame_cnt", frame_cnt, active ? nf : 0);
    @(posedge clk); #1;
    check_output("done_one_cycle", done, 0);
    check_output("all_beats_seen", exp_q.size(), 0);
  endtask

  task automatic apply_stimulus_abort();
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 0), (k == 15), ram_model[k]});
    frame_len = 16; num_frames = 1; gap_cycles = 0;
    m_axis_tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    check_output("abort_pre_beat", m_axis_tdata, 5);
    m_axis_tready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    m_axis_tready = 1'b1;
    exp_q.delete();
    check_output("abort_flush", {m_axis_tvalid, busy, done}, 3'b000);
    @(posedge clk); #1;
    check_output("abort_no_done", {m_axis_tvalid, done}, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done}, 5'b0);
    check_output("reset_tdata", m_axis_tdata, 0);
    check_output("reset_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus_load(0, DEPTH, 0);
    $display("[TB] single frame, full throughput");
    apply_stimulus_run(16, 1, 0, 0, 17);
`ifdef AXIS_FRAME_SRC_CSUM_EN
    check_output("csum_0_to_15", frame_csum, 120);
`endif
    $display("[TB] single frame with backpressure");
    apply_stimulus_run(16, 1, 0, 1, -1);
    $display("[TB] three frames with gaps");
    apply_stimulus_run(4, 3, 2, 0, 17);
    apply_stimulus_run(4, 3, 0, 0, 13);
    apply_stimulus_run(1, 2, 0, 0, 3);
    $display("[TB] degenerate and clamped lengths");
    apply_stimulus_run(0, 1, 0, 0, 0);
    apply_stimulus_run(4, 0, 0, 0, 0);
    apply_stimulus_run(2**(ADDR_W+1) - 1, 1, 0, 0, 65);
    $display("[TB] abort and replay");
    apply_stimulus_abort();
    apply_stimulus_run(16, 1, 0, 0, 17);
    $display("[TB] reloaded image");
    apply_stimulus_load(0, 4, 8'hA0);
    apply_stimulus_run(4, 2, 1, 0, 10);
`ifdef AXIS_FRAME_SRC_CSUM_EN
    check_output("csum_reload", frame_csum, 32'hA0 + 32'hA1 + 32'hA2 + 32'hA3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
# axis_frame_source

Parametrised AXI-Stream frame replay engine that stores one image in on-chip RAM and streams it to a downstream pixel pipeline (e.g. the MRELBP `s_axis` input) for a programmable number of frames. It replaces hand-written pixel-feeding loops with a synthesizable, backpressure-correct source. It supports multi-frame runs, inter-frame gaps, frame markers and abort, so it can be used both on-chip and in system-level benches.

## Interface
Parameters:
- `DATA_W`, 8, pixel/beat width.
- `ADDR_W`, 15, RAM address width; depth = 2**ADDR_W.
- `FRM_W`, 8, width of frame count.
- `GAP_W`, 16, width of inter-frame gap count.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_we`  in  1  RAM write enable (image load).
- `mem_waddr`  in  ADDR_W  RAM write address.
- `mem_wdata`  in  DATA_W  RAM write data.
- `start`  in  1  level-sampled; starts a run when idle.
- `abort`  in  1  terminates a run.
- `frame_len`  in  ADDR_W+1  beats per frame; latched at start.
- `num_frames`  in  FRM_W  frames per run; latched at start.
- `gap_cycles`  in  GAP_W  idle cycles between frames; latched at start.
- `m_axis_tdata`  out  DATA_W  pixel.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tuser`  out  1  first beat of frame (SOF).
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.
- `frame_cnt`  out  FRM_W  frames completed in current/last run.

## Operation
- States: IDLE, PRIME, STREAM, GAP.
- IDLE: `start`=1 latches the config, clears `frame_cnt`, and enters PRIME.
  - If the latched `frame_len`==0 or `num_frames`==0: no beats are sent, `done` pulses next cycle, and the block stays in IDLE.
- `frame_len` > 2**ADDR_W is clamped to 2**ADDR_W.
- PRIME: issue RAM read of address 0, then go to STREAM.
- STREAM: beat k carries RAM[k], k = 0..frame_len-1. Every frame restarts at address 0.
  - `tuser`=1 on k=0 only.
  - `tlast`=1 on k=frame_len-1 only.
  - With frame_len=1, both `tuser` and `tlast` are 1.
- Handshake: a beat transfers when `tvalid`&&`tready`. While `tvalid`=1 and `tready`=0, `tdata`/`tlast`/`tuser` hold stable and `tvalid` stays 1.
- Internal prefetch (one-deep skid after the RAM's 1-cycle read) is required so that throughput is one beat/cycle whenever `tready`=1.
- On the last-beat handshake, `frame_cnt` increments. Then:
  - If `frame_cnt`+1 == `num_frames`: return to IDLE.
  - Else if `gap_cycles`>0: go to GAP.
  - Else: continue streaming the next frame back-to-back.
- GAP: `tvalid`=0 for exactly `gap_cycles` cycles, then STREAM.
- `start` while `busy` is ignored.
- `abort`=1 in any state: next cycle IDLE, `tvalid`=0, `busy`=0, and no `done` pulse. The partial beat is dropped (intentional flush). Abort has priority over start.
- RAM writes are accepted in any state. Read-during-write to the same address returns old data.

## Timing
- Reset: `tvalid`=0, `tdata`=0, `tlast`=0, `tuser`=0, `busy`=0, `done`=0, `frame_cnt`=0; state IDLE. RAM contents are not reset.
- `start` sampled high at edge T: `busy`=1 from T+1, and first beat `tvalid`=1 from T+2.
- `tready` held high: frame of N beats occupies N consecutive cycles.
- Last handshake of final frame at edge E: at E+1, `tvalid`=0, `busy`=0, and `done`=1 for exactly one cycle. `frame_cnt` equals `num_frames`.
- Gap G>0: `tvalid` is low for exactly G cycles between the `tlast` handshake and the next `tuser` beat. G=0 gives no bubble.

## Configuration
- `AXIS_FRAME_SRC_CSUM_EN` defined: adds output `frame_csum` [31:0].
  - It is the modulo-2^32 sum of all `tdata` transferred in the most recently completed frame.
  - It updates on the cycle after that frame's `tlast` handshake and resets to 0.
  - Abort leaves it unchanged.
- Not defined: the port and the accumulator are absent. Behaviour is otherwise identical.

## Test plan
- Load RAM[i]=i&0xFF, frame_len=16, num_frames=1, tready=1 → 16 beats 0..15 in consecutive cycles starting T+2; tuser on beat 0, tlast on beat 15; done at handshake+1; frame_cnt=1.
- Same load, tready toggling 1,0,0,1 pattern → data stable during stalls, sequence 0..15 intact, no duplicates or drops.
- frame_len=4, num_frames=3, gap_cycles=2 → beats 0,1,2,3, two idle cycles, repeated ×3; frame_cnt=3; with gap_cycles=0, 12 contiguous beats.
- frame_len=0 → no tvalid, done one cycle after start; frame_len=2**(ADDR_W+1)-1 → exactly 2**ADDR_W beats.
- abort asserted mid-frame (beat 5 of 16) while tready=0 → tvalid=0 next cycle, busy=0, no done; a new start replays from beat 0 with tuser.
- With `AXIS_FRAME_SRC_CSUM_EN`, RAM[i]=i, frame_len=16 → frame_csum=120 after tlast.
